// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-access pipeline stage. Non-memory instructions pass
//            straight through to write-back one cycle later. Loads and stores
//            are issued on a registered data bus and the stage stalls the
//            pipeline until the bus acknowledges or a timeout expires.
//            Byte lanes are big-endian: addr[1:0]=0 selects bits [31:24].
//
// Parameters:
//   TIMEOUT_CYCLES  maximum BUSY cycles without mem_ack_i before abort
//
// Optional feature macro:
//   MEM_ALIGN_CHECK_EN  misaligned halfword/word accesses are rejected with
//                       err_o instead of being forced onto an aligned address
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   valid_i, aluop_i  instruction valid and operation code
//   mem_addr_i        effective address
//   reg2_i            store data source
//   wd_i/wreg_i/wdata_i  destination reg, write enable, ALU result
//   wd_o/wreg_o/wdata_o/valid_o  registered write-back outputs
//   stallreq_o        combinational upstream stall request
//   mem_req_o/mem_we_o/mem_sel_o/mem_addr_o/mem_data_o  registered bus outputs
//   mem_ack_i/mem_data_i  bus acknowledge and read data
//   err_o             one-cycle pulse on timeout or misalignment
//
// Revision : 1.0  initial release
// ============================================================================
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        valid_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        err_o
);

  // Operation codes (EXE_*_OP encoding)
  localparam logic [7:0] c_OP_LB  = 8'b1110_0000;
  localparam logic [7:0] c_OP_LH  = 8'b1110_0001;
  localparam logic [7:0] c_OP_LW  = 8'b1110_0011;
  localparam logic [7:0] c_OP_LBU = 8'b1110_0100;
  localparam logic [7:0] c_OP_LHU = 8'b1110_0101;
  localparam logic [7:0] c_OP_SB  = 8'b1110_1000;
  localparam logic [7:0] c_OP_SH  = 8'b1110_1001;
  localparam logic [7:0] c_OP_SW  = 8'b1110_1011;

  localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;

  logic [4:0]        r_wd;
  logic              r_wreg;
  logic              r_wreg_cap;
  logic [31:0]       r_wdata;
  logic              r_valid;
  logic              r_err;
  logic              r_req;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic [7:0]        r_op;

  logic              w_is_byte, w_is_half, w_is_word, w_is_mem, w_is_store;
  logic [31:0]       w_addr;
  logic [3:0]        w_sel;
  logic [31:0]       w_sdata;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [31:0]       w_load_data;
  logic              w_stall, w_start, w_align_err, w_done, w_abort, w_timeout;

  // --------------------------------------------------------------------------
  // Request decode: access size, forced-aligned address, lane select, data
  // --------------------------------------------------------------------------
  always_comb begin
    w_is_byte  = (aluop_i == c_OP_LB) || (aluop_i == c_OP_LBU) || (aluop_i == c_OP_SB);
    w_is_half  = (aluop_i == c_OP_LH) || (aluop_i == c_OP_LHU) || (aluop_i == c_OP_SH);
    w_is_word  = (aluop_i == c_OP_LW) || (aluop_i == c_OP_SW);
    w_is_mem   = w_is_byte || w_is_half || w_is_word;
    w_is_store = (aluop_i == c_OP_SB) || (aluop_i == c_OP_SH) || (aluop_i == c_OP_SW);

    // Word accesses always present addr[1:0]=00 on the bus; halfwords clear
    // addr[0]. With the alignment check enabled only aligned accesses get
    // here, so the forcing is a no-op in that build.
    w_addr = mem_addr_i;
    if (w_is_word) begin
      w_addr[1:0] = 2'b00;
    end else if (w_is_half) begin
      w_addr[0] = 1'b0;
    end

    w_sel   = 4'b0000;
    w_sdata = 32'h0000_0000;
    if (w_is_byte) begin
      w_sel   = 4'b1000 >> w_addr[1:0];
      w_sdata = {4{reg2_i[7:0]}};
    end else if (w_is_half) begin
      w_sel   = w_addr[1] ? 4'b0011 : 4'b1100;
      w_sdata = {2{reg2_i[15:0]}};
    end else if (w_is_word) begin
      w_sel   = 4'b1111;
      w_sdata = reg2_i;
    end
    if (!w_is_store) begin
      w_sdata = 32'h0000_0000;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = (w_is_half & mem_addr_i[0]) |
                      (w_is_word & (mem_addr_i[1:0] != 2'b00));
`endif

  // --------------------------------------------------------------------------
  // Load formatting from the lane captured at issue
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_lane_b = mem_data_i[31:24];
      2'd1:    w_lane_b = mem_data_i[23:16];
      2'd2:    w_lane_b = mem_data_i[15:8];
      default: w_lane_b = mem_data_i[7:0];
    endcase
    w_lane_h = r_addr[1] ? mem_data_i[15:0] : mem_data_i[31:16];

    case (r_op)
      c_OP_LB:  w_load_data = {{24{w_lane_b[7]}}, w_lane_b};
      c_OP_LBU: w_load_data = {24'h00_0000, w_lane_b};
      c_OP_LH:  w_load_data = {{16{w_lane_h[15]}}, w_lane_h};
      c_OP_LHU: w_load_data = {16'h0000, w_lane_h};
      default:  w_load_data = mem_data_i;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_align_err = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_timeout   = (r_cnt == c_CNT_LAST);

    case (r_state)
      ST_IDLE: begin
        if (valid_i && w_is_mem) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (w_misalign) begin
            w_align_err = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = ST_BUSY;
          end
`else
          w_start     = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        // An acknowledge in the timeout cycle still completes normally.
        if (mem_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wd       <= 5'd0;
      r_wreg     <= 1'b0;
      r_wreg_cap <= 1'b0;
      r_wdata    <= 32'h0000_0000;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= 4'b0000;
      r_addr     <= 32'h0000_0000;
      r_data     <= 32'h0000_0000;
      r_op       <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      // valid/err/wreg are single-cycle retire strobes
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_wreg  <= 1'b0;

      if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end

      if (w_start) begin
        r_cnt      <= '0;
        r_req      <= 1'b1;
        r_we       <= w_is_store;
        r_sel      <= w_sel;
        r_addr     <= w_addr;
        r_data     <= w_sdata;
        r_op       <= aluop_i;
        r_wd       <= wd_i;
        r_wreg_cap <= wreg_i & ~w_is_store;
      end else if (w_align_err) begin
        r_valid <= 1'b1;
        r_err   <= 1'b1;
        r_wd    <= wd_i;
      end else if (w_done) begin
        r_req   <= 1'b0;
        r_valid <= 1'b1;
        r_wreg  <= r_wreg_cap;
        r_wdata <= w_load_data;
      end else if (w_abort) begin
        r_req   <= 1'b0;
        r_valid <= 1'b1;
        r_err   <= 1'b1;
      end else if ((r_state == ST_IDLE) && valid_i && !w_is_mem) begin
        r_valid <= 1'b1;
        r_wd    <= wd_i;
        r_wreg  <= wreg_i;
        r_wdata <= wdata_i;
      end
    end
  end

  assign wd_o       = r_wd;
  assign wreg_o     = r_wreg;
  assign wdata_o    = r_wdata;
  assign valid_o    = r_valid;
  assign err_o      = r_err;
  assign mem_req_o  = r_req;
  assign mem_we_o   = r_we;
  assign mem_sel_o  = r_sel;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_data;
  // No stall is requested while reset is held.
  assign stallreq_o = w_stall & rst;

endmodule
`default_nettype wire
